bus_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the `select` line of the 2:1 bus multiplexer. It sits directly upstream of the multiplexer. Source A drives the multiplexer's `a` input and source B drives its `b` input; this block decides which source reaches `out`. Grants are registered and held until the owner releases. Ownership hands over without an idle cycle when the other side is waiting.

---
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin arbiter driving the select line of a
// 2:1 bus multiplexer. Grants are registered and held until the owner releases
// (done pulse or dropped request); a waiting requester takes over with no idle
// cycle in between.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to revoke an owner that has
// held the bus for HOLD_MAX cycles while the other side is requesting.
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic done_a,
  input  logic done_b,
  output logic grant_a,
  output logic grant_b,
  output logic select,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_b = 1 when B was the most recent owner (A then wins the next tie)
  logic last_b;
  logic last_b_nxt;
  logic select_q;
  logic select_nxt;

  logic owner_release;
  logic other_req;
  logic hold_expired;
  logic revoke;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("bus_arbiter: HOLD_MAX must be in 2..255");
  end

  // Release condition and competing request, seen from the current owner
  assign owner_release = ((state == OWN_A) && (done_a || !req_a)) ||
                         ((state == OWN_B) && (done_b || !req_b));
  assign other_req     = ((state == OWN_A) && req_b) ||
                         ((state == OWN_B) && req_a);
  // A voluntary release always takes precedence over a forced handoff
  assign revoke        = hold_expired && !owner_release && other_req;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  // Hold counter: clears on any state entry, saturates at HOLD_MAX-1 while owned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state_nxt != state) begin
      hold_cnt <= '0;
    end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // Timeout pulse: high during the first cycle after a forced handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= revoke;
    end
  end

  assign hold_expired = (state != IDLE) && (hold_cnt == HOLD_LAST);
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // State, priority flag and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      select_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      select_q <= select_nxt;
    end
  end

  // Next-state selection; select and priority follow whichever side is entered
  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    select_nxt = select_q;

    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt = last_b ? OWN_A : OWN_B;
        end else if (req_a) begin
          state_nxt = OWN_A;
        end else if (req_b) begin
          state_nxt = OWN_B;
        end
      end
      OWN_A: begin
        if (owner_release) begin
          state_nxt = req_b ? OWN_B : IDLE;
        end else if (revoke) begin
          state_nxt = OWN_B;
        end
      end
      OWN_B: begin
        if (owner_release) begin
          state_nxt = req_a ? OWN_A : IDLE;
        end else if (revoke) begin
          state_nxt = OWN_A;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt == OWN_A) begin
      last_b_nxt = 1'b0;
      select_nxt = 1'b0;
    end else if (state_nxt == OWN_B) begin
      last_b_nxt = 1'b1;
      select_nxt = 1'b1;
    end
  end

  assign grant_a = (state == OWN_A);
  assign grant_b = (state == OWN_B);
  assign busy    = grant_a | grant_b;
  assign select  = select_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner
// sequences, then randomized stimulus against a behavioural ownership model.
module tb_bus_arbiter;

  localparam int unsigned HOLD = 4;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, done_a = 1'b0, done_b = 1'b0;
  logic grant_a, grant_b, select, busy, timeout;

  int total = 0;
  int bad = 0;

  bus_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .done_a(done_a), .done_b(done_b),
    .grant_a(grant_a), .grant_b(grant_b), .select(select),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ra, rb, da, db;
    logic ga, gb, sel, bsy, to;
  } vec_t;

  vec_t tbl[13];

  // Reference model: owner index (-1 none, 0 A, 1 B), cycles held so far
  int m_owner, m_last, m_held;
  bit m_sel, m_tout;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic ga, input logic gb,
                         input logic sel, input logic bsy, input logic to);
    chk({nm, ".grant_a"}, grant_a, ga);
    chk({nm, ".grant_b"}, grant_b, gb);
    chk({nm, ".select"},  select,  sel);
    chk({nm, ".busy"},    busy,    bsy);
    chk({nm, ".timeout"}, timeout, to);
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_sel = 1'b0; m_held = 0; m_tout = 1'b0;
  endtask

  task automatic model_step(input logic ra, input logic rb,
                            input logic da, input logic db);
    bit req[2];
    bit dn[2];
    int nxt;
    int o;
    req[0] = ra; req[1] = rb; dn[0] = da; dn[1] = db;
    m_tout = 1'b0;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (req[0] && req[1]) nxt = 1 - m_last;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
    end else begin
      o = 1 - m_owner;
      if (dn[m_owner] || !req[m_owner]) begin
        nxt = req[o] ? o : -1;
      end else if (TO_EN && m_held >= int'(HOLD) && req[o]) begin
        nxt = o;
        m_tout = 1'b1;
      end
    end
    if (nxt != m_owner) m_held = (nxt >= 0) ? 1 : 0;
    else if (nxt >= 0 && m_held < 1000) m_held++;
    if (nxt >= 0) begin
      m_last = nxt;
      m_sel  = (nxt == 1);
    end
    m_owner = nxt;
  endtask

  task automatic drive(input logic ra, input logic rb, input logic da, input logic db);
    req_a = ra; req_b = rb; done_a = da; done_b = db;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply inputs at the falling edge, sample 1 time unit after the next rising edge
  task automatic step(input logic ra, input logic rb, input logic da, input logic db);
    @(negedge clk);
    drive(ra, rb, da, db);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ra rb da db   ga gb sel bsy to
    tbl[0]  = '{1, 0, 0, 0,   1, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0,   1, 0, 0, 1, 0};
    tbl[2]  = '{1, 1, 1, 0,   0, 1, 1, 1, 0};
    tbl[3]  = '{1, 1, 0, 1,   1, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 1, 0,   0, 1, 1, 1, 0};
    tbl[5]  = '{0, 1, 1, 0,   0, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 0,   0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,   0, 0, 1, 0, 0};
    tbl[8]  = '{1, 1, 0, 0,   1, 0, 0, 1, 0};
    tbl[9]  = '{1, 0, 1, 0,   0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 0,   1, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 0,   0, 1, 1, 1, 0};

    // Reset values, checked while reset is held
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    do_reset();
    chk_all("post_reset", 0, 0, 0, 0, 0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db);
      chk_all($sformatf("vec%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].sel,
              tbl[i].bsy, tbl[i].to);
    end

    // Alternating handoff with both requests held
    do_reset();
    step(1, 1, 0, 0);
    chk_all("alt0", 1, 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 1) begin
        step(1, 1, 1, 0);
        chk_all($sformatf("alt%0d", i), 0, 1, 1, 1, 0);
      end else begin
        step(1, 1, 0, 1);
        chk_all($sformatf("alt%0d", i), 1, 0, 0, 1, 0);
      end
    end

    // done_b while A owns the bus has no effect
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk_all("stray_done_b", 1, 0, 0, 1, 0);

    // Hold timeout: A owns, B waits, no done
    do_reset();
    step(1, 0, 0, 0);
    chk_all("hold1", 1, 0, 0, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      step(1, 1, 0, 0);
      chk_all($sformatf("hold%0d", i), 1, 0, 0, 1, 0);
    end
    step(1, 1, 0, 0);
    if (TO_EN) chk_all("hold_revoke", 0, 1, 1, 1, 1);
    else       chk_all("hold_keep", 1, 0, 0, 1, 0);
    step(1, 1, 0, 0);
    if (TO_EN) chk_all("hold_after", 0, 1, 1, 1, 0);
    else       chk_all("hold_keep2", 1, 0, 0, 1, 0);

    // Asynchronous reset between clock edges while A owns
    do_reset();
    step(1, 0, 0, 0);
    chk_all("pre_areset", 1, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("areset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    chk_all("after_areset", 0, 1, 1, 1, 0);

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic ra, rb, da, db;
      @(negedge clk);
      chk_all($sformatf("rnd%0d", c), m_owner == 0, m_owner == 1, m_sel,
              m_owner >= 0, m_tout);
      ra = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 3) != 0);
      da = ($urandom_range(0, 4) == 0);
      db = ($urandom_range(0, 4) == 0);
      drive(ra, rb, da, db);
      model_step(ra, rb, da, db);
    end
    @(negedge clk);
    chk_all("rnd_end", m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_tout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
